// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC source encodings, hazard FSM states,
// and the hard-wired zero register number.
package pipe_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_J   = 2'd1;
  localparam logic [1:0] PCSRC_JR  = 2'd2;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_dep_match.sv
// dep_match: register dependency comparator. A producer with a valid write
// to dst matches a consumer reading src; register 0 never matches.
module dep_match
  import pipe_pkg::*;
(
  input  logic       valid_i,
  input  logic [4:0] dst_i,
  input  logic [4:0] src_i,
  output logic       match_o
);

  assign match_o = valid_i && (dst_i == src_i) && (src_i != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / jr-dependency stall and control-redirect flush
// generation. Outputs are Mealy from the registered state and current inputs.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// the STAT_W parameter exists only in that build.
//
// state    | meaning
// ST_RUN   | normal flow; hazards evaluated each cycle
// ST_STALL | committed extra stall cycle of a jr-after-load; inputs ignored
module hazard_ctrl
  import pipe_pkg::*;
`ifdef HAZARD_STATS_EN
#(
  parameter int STAT_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRt,
  input  logic [1:0]        ID_PCSrc,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [4:0]        EX_Dst,
  input  logic              MEM_MemRead,
  input  logic [4:0]        MEM_Dst,
  input  logic              EX_BranchTaken,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_Flush,
  output logic              ID_Flush,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] Stall_Cycles,
  output logic [STAT_W-1:0] Flush_Count,
`endif
  output logic              Stall_Active
);

  hazard_state_t state_q, state_d;
  logic [1:0]    stall_cnt_q, stall_cnt_d;

  logic lu_rs, lu_rt, ex_rs, mem_rs;
  logic is_jr, is_jump;
  logic [1:0] need;

  dep_match u_lu_rs  (.valid_i(EX_MemRead),             .dst_i(EX_Dst),  .src_i(ID_Rs), .match_o(lu_rs));
  dep_match u_lu_rt  (.valid_i(EX_MemRead & ID_UsesRt), .dst_i(EX_Dst),  .src_i(ID_Rt), .match_o(lu_rt));
  dep_match u_ex_rs  (.valid_i(EX_RegWrite),            .dst_i(EX_Dst),  .src_i(ID_Rs), .match_o(ex_rs));
  dep_match u_mem_rs (.valid_i(MEM_MemRead),            .dst_i(MEM_Dst), .src_i(ID_Rs), .match_o(mem_rs));

  assign is_jr   = (ID_PCSrc == PCSRC_JR);
  assign is_jump = (ID_PCSrc == PCSRC_J) || is_jr;

  // Required stall length: jr waiting on a load needs two cycles, everything else one.
  always_comb begin
    need = 2'd0;
    if (is_jr && lu_rs)
      need = 2'd2;
    else if (lu_rs || lu_rt || (is_jr && (ex_rs || mem_rs)))
      need = 2'd1;
  end

  // Output decode and next state; a taken branch overrides any stall or jump.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_Flush    = 1'b1;
      ID_Flush    = 1'b1;
      state_d     = ST_RUN;
      stall_cnt_d = 2'd0;
    end else if (EX_BranchTaken) begin
      IF_Flush    = 1'b1;
      ID_Flush    = 1'b1;
      state_d     = ST_RUN;
      stall_cnt_d = 2'd0;
    end else if (state_q == ST_STALL) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_Flush    = 1'b1;
      stall_cnt_d = stall_cnt_q - 2'd1;
      if (stall_cnt_q <= 2'd1) state_d = ST_RUN;
    end else if (need != 2'd0) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_Flush    = 1'b1;
      if (need == 2'd2) begin
        state_d     = ST_STALL;
        stall_cnt_d = 2'd1;
      end
    end else begin
      IF_Flush = is_jump;
    end
  end

  // State register; reset aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Active = (state_q == ST_STALL);

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, flush_count_q;

  // Saturating stall-cycle and IF-flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!PC_Write && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (IF_Flush && (flush_count_q != '1))   flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign Stall_Cycles = stall_cycles_q;
  assign Flush_Count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl, plus statistics sequences
// when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Dst, MEM_Dst;
  logic       ID_UsesRt, EX_MemRead, EX_RegWrite, MEM_MemRead, EX_BranchTaken;
  logic [1:0] ID_PCSrc;
  logic       PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Stall_Active;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] Stall_Cycles, Flush_Count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  hazard_ctrl #(.STAT_W(SW)) dut (
`else
  hazard_ctrl dut (
`endif
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_PCSrc(ID_PCSrc),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Dst(EX_Dst),
    .MEM_MemRead(MEM_MemRead), .MEM_Dst(MEM_Dst), .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
`ifdef HAZARD_STATS_EN
    .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count),
`endif
    .Stall_Active(Stall_Active)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [1:0] pcsrc;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_dst;
    logic       mem_mr;
    logic [4:0] mem_dst;
    logic       br;
    logic [4:0] exp;   // {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Stall_Active}
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic drive(input vec_t v);
    rst = v.rst; ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt; ID_PCSrc = v.pcsrc;
    EX_MemRead = v.ex_mr; EX_RegWrite = v.ex_rw; EX_Dst = v.ex_dst;
    MEM_MemRead = v.mem_mr; MEM_Dst = v.mem_dst; EX_BranchTaken = v.br;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {PC_Write, IF_ID_Write, IF_Flush, ID_Flush, Stall_Active};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {pcw,ifidw,iffl,idfl,act}=%b expected %b", name, act, exp);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic check_stat(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
`endif

  // Apply one vector, sample mid-cycle, then advance past the rising edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #2;
    check_out(name, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst rs  rt  urt pc    emr erw edst mmr mdst br  exp
    vecs[0]  = '{1, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b00110};
    vecs[1]  = '{1, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b00110};
    vecs[2]  = '{0, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b11000};
    vecs[3]  = '{0, 8,  0,  0, 2'd0, 1, 1, 8,  0, 0,  0, 5'b00010};
    vecs[4]  = '{0, 8,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b11000};
    vecs[5]  = '{0, 0,  0,  0, 2'd0, 1, 1, 0,  0, 0,  0, 5'b11000};
    vecs[6]  = '{0, 3,  9,  1, 2'd0, 1, 1, 9,  0, 0,  0, 5'b00010};
    vecs[7]  = '{0, 3,  9,  0, 2'd0, 1, 1, 9,  0, 0,  0, 5'b11000};
    vecs[8]  = '{0, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  0, 5'b00010};
    vecs[9]  = '{0, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  0, 5'b00011};
    vecs[10] = '{0, 31, 0,  0, 2'd2, 0, 0, 0,  0, 0,  0, 5'b11100};
    vecs[11] = '{0, 5,  0,  0, 2'd2, 0, 1, 5,  0, 0,  0, 5'b00010};
    vecs[12] = '{0, 5,  0,  0, 2'd2, 0, 0, 0,  0, 0,  0, 5'b11100};
    vecs[13] = '{0, 7,  0,  0, 2'd2, 0, 0, 0,  1, 7,  0, 5'b00010};
    vecs[14] = '{0, 0,  0,  0, 2'd1, 0, 0, 0,  0, 0,  0, 5'b11100};
    vecs[15] = '{0, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b11000};
    vecs[16] = '{0, 0,  0,  0, 2'd3, 0, 0, 0,  0, 0,  0, 5'b11000};
    vecs[17] = '{0, 5,  0,  0, 2'd0, 0, 1, 5,  1, 5,  0, 5'b11000};
    vecs[18] = '{0, 8,  0,  0, 2'd1, 1, 1, 8,  0, 0,  1, 5'b11110};
    vecs[19] = '{0, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  0, 5'b00010};
    vecs[20] = '{0, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  1, 5'b11111};
    vecs[21] = '{0, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b11000};
    vecs[22] = '{0, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  0, 5'b00010};
    vecs[23] = '{1, 31, 0,  0, 2'd2, 1, 1, 31, 0, 0,  0, 5'b00111};
    vecs[24] = '{0, 0,  0,  0, 2'd0, 0, 0, 0,  0, 0,  0, 5'b11000};

    drive(vecs[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) step(vecs[i], $sformatf("vec%0d", i));

`ifdef HAZARD_STATS_EN
    // Reset then: load-use (1 stall), jr-after-load (2 stalls), jr, branch, jump.
    step(vecs[0], "stat_rst");
    check_stat("stall_cycles_rst", Stall_Cycles, 4'd0);
    check_stat("flush_count_rst", Flush_Count, 4'd0);
    step(vecs[3],  "stat_lu");
    step(vecs[4],  "stat_bubble");
    step(vecs[8],  "stat_jr1");
    step(vecs[9],  "stat_jr2");
    step(vecs[10], "stat_jr_go");
    step(vecs[18], "stat_branch");
    step(vecs[14], "stat_jump");
    step(vecs[15], "stat_idle");
    check_stat("stall_cycles_seq", Stall_Cycles, 4'd3);
    check_stat("flush_count_seq", Flush_Count, 4'd3);
    for (int i = 0; i < 16; i++) step(vecs[3], "stat_lu_sat");
    for (int i = 0; i < 16; i++) step(vecs[14], "stat_j_sat");
    check_stat("stall_cycles_sat", Stall_Cycles, 4'hF);
    check_stat("flush_count_sat", Flush_Count, 4'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that generates the `ID_Flush` consumed by the ID/EX register, the IF/ID write/flush controls and the PC write enable. It detects three hazards:
- load-use data hazards;
- `jr` register dependencies resolved in ID;
- control redirects from jumps (ID) and taken branches (EX).

It is a small registered FSM that commits to a stall length on entry. The bubble inserted into ID/EX never re-triggers detection.

## Interface
Parameters:
- `STAT_W`, 32: width of the statistics counters (used only with `HAZARD_STATS_EN`).

Ports:
- `clk` input 1: clock. One clock domain. Reset is synchronous and active-high.
- `rst` input 1: synchronous active-high reset.
- `ID_Rs`, `ID_Rt` input 5 each: source register numbers of the instruction in ID.
- `ID_UsesRt` input 1: the ID instruction reads Rt.
- `ID_PCSrc` input 2: `PCSRC_SEQ`=0, `PCSRC_J`=1 (j/jal), `PCSRC_JR`=2 (jr/jalr), 3 reserved (treated as SEQ).
- `EX_MemRead`, `EX_RegWrite` input 1 each: controls of the instruction in EX.
- `EX_Dst` input 5: EX destination register after the RegDst mux.
- `MEM_MemRead` input 1, `MEM_Dst` input 5: load indicator and destination of the instruction in MEM.
- `EX_BranchTaken` input 1: the branch in EX resolved taken.
- `PC_Write` output 1: PC update enable.
- `IF_ID_Write` output 1: IF/ID update enable.
- `IF_Flush` output 1: zero IF/ID at the next edge.
- `ID_Flush` output 1: zero ID/EX at the next edge.
- `Stall_Active` output 1: registered; 1 while in `ST_STALL`.
- `Stall_Cycles`, `Flush_Count` output `STAT_W` each: statistics, present only with `HAZARD_STATS_EN`.

## Operation
- States: `ST_RUN` and `ST_STALL`. The 2-bit `stall_cnt` holds the stall cycles remaining after the current one.
- A register number of 0 never matches any dependency.
- Required stall length `need`, evaluated only in `ST_RUN`:
  - load-use: `EX_MemRead` and `EX_Dst` equals `ID_Rs`, or equals `ID_Rt` when `ID_UsesRt` → need = 1;
  - jr with `EX_MemRead` and `EX_Dst`==`ID_Rs` → need = 2;
  - jr with (`EX_RegWrite` and `EX_Dst`==`ID_Rs`) or (`MEM_MemRead` and `MEM_Dst`==`ID_Rs`) → need = 1;
  - when several apply, need takes the maximum; otherwise need = 0.
- Stall cycle outputs: `PC_Write`=0, `IF_ID_Write`=0, `ID_Flush`=1, `IF_Flush`=0.
- `ST_RUN`, need=0: `PC_Write`=1, `IF_ID_Write`=1, `ID_Flush`=0. `IF_Flush`=1 iff `ID_PCSrc`==`PCSRC_J` or `PCSRC_JR`.
- `ST_RUN`, need≥1: drive the stall outputs this cycle. If need=2, go to `ST_STALL` with `stall_cnt`=1; if need=1, stay in `ST_RUN`.
- `ST_STALL`: drive the stall outputs without evaluating any hazard inputs. Decrement `stall_cnt`; when it reaches 0, return to `ST_RUN`.
- `EX_BranchTaken` has the highest priority in every state:
  - outputs `PC_Write`=1, `IF_ID_Write`=1, `IF_Flush`=1, `ID_Flush`=1;
  - next state `ST_RUN` with `stall_cnt`=0, cancelling any pending stall;
  - no jump or stall is recognised in that cycle.
- While `rst`=1:
  - outputs `PC_Write`=0, `IF_ID_Write`=0, `IF_Flush`=1, `ID_Flush`=1;
  - at the edge: state `ST_RUN`, `stall_cnt`=0, `Stall_Active`=0, statistics counters cleared to 0.
- A reset asserted mid-stall aborts the stall at that edge.

## Timing
- Flush and write-enable outputs are combinational (Mealy) from the registered state and the current inputs. They take effect at the same rising edge as the pipeline registers they control, so the reaction latency is 0 cycles.
- `Stall_Active` is registered and lags the state transition by 0 cycles (it is the state bit itself).
- Every stall is exactly `need` cycles long. The following cycle always evaluates hazards fresh in `ST_RUN`.
- No combinational path runs from any output back to any input.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `Stall_Cycles` increments on every cycle with `PC_Write`=0 and `rst`=0;
  - `Flush_Count` increments on every cycle with `IF_Flush`=1 and `rst`=0;
  - both saturate at all-ones.
- `HAZARD_STATS_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - `PCSRC_SEQ`/`PCSRC_J`/`PCSRC_JR` constants;
  - the `hazard_state_t` enum (`ST_RUN`, `ST_STALL`);
  - the `REG_ZERO` constant.
- One sub-module, `dep_match`, is natural: a combinational comparator (valid, dst, src → match with zero-register masking). It is instantiated per dependency check.
- The FSM and counters stay in `hazard_ctrl`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → `ID_Flush`=1, `IF_Flush`=1, `PC_Write`=0, `Stall_Active`=0. After release with no hazards → `PC_Write`=1, all flushes 0.
- **Load-use:** `EX_MemRead`=1, `EX_Dst`=8, `ID_Rs`=8 → one cycle with `PC_Write`=0, `IF_ID_Write`=0, `ID_Flush`=1. Next cycle (bubble in EX) → normal flow. With `EX_Dst`=0 → no stall.
- **jr after load:** `ID_PCSrc`=2, `ID_Rs`=31, `EX_MemRead`=1, `EX_Dst`=31 → 2 stall cycles with `Stall_Active`=1 in the second, then `IF_Flush`=1 for the jr.
- **Branch priority:** branch taken during `ST_STALL` with `stall_cnt`=1 → `IF_Flush`=`ID_Flush`=`PC_Write`=1; next cycle `ST_RUN`, no residual stall.
- **Jump:** `ID_PCSrc`=1, no dependencies → `IF_Flush`=1, `ID_Flush`=0, `PC_Write`=1 for exactly one cycle.
- **Stats (`HAZARD_STATS_EN`):** the above sequence → `Stall_Cycles`=3, `Flush_Count`=3 after reset release. Counters preloaded near max saturate at all-ones.
